// File: rtl/issue_queue.sv
// Age-ordered issue queue: captures renamed instructions, wakes sources from
// result buses and offers the oldest ready entry to each functional unit.
module issue_queue #(
  parameter int DEPTH     = 16,
  parameter int N_DISP    = 2,
  parameter int N_FU      = 3,
  parameter int N_WB      = 3,
  parameter int TAG_W     = 7,
  parameter int XLEN      = 32,
  parameter int ROB_W     = 4,
  parameter int PAYLOAD_W = 48,
  localparam int FU_W     = (N_FU > 1) ? $clog2(N_FU) : 1,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_flush,
  input  logic [N_DISP-1:0]                  i_disp_valid,
  output logic                               o_disp_ready,
  input  logic [N_DISP-1:0][TAG_W-1:0]       i_disp_src0_tag,
  input  logic [N_DISP-1:0][TAG_W-1:0]       i_disp_src1_tag,
  input  logic [N_DISP-1:0]                  i_disp_src0_rdy,
  input  logic [N_DISP-1:0]                  i_disp_src1_rdy,
  input  logic [N_DISP-1:0][XLEN-1:0]        i_disp_src0_data,
  input  logic [N_DISP-1:0][XLEN-1:0]        i_disp_src1_data,
  input  logic [N_DISP-1:0][TAG_W-1:0]       i_disp_dst_tag,
  input  logic [N_DISP-1:0][ROB_W-1:0]       i_disp_rob,
  input  logic [N_DISP-1:0][FU_W-1:0]        i_disp_fu,
  input  logic [N_DISP-1:0][PAYLOAD_W-1:0]   i_disp_payload,
  input  logic [N_WB-1:0]                    i_wb_valid,
  input  logic [N_WB-1:0][TAG_W-1:0]         i_wb_tag,
  input  logic [N_WB-1:0][XLEN-1:0]          i_wb_data,
  output logic [N_FU-1:0]                    o_iss_valid,
  input  logic [N_FU-1:0]                    i_iss_ready,
  output logic [N_FU-1:0][XLEN-1:0]          o_iss_src0,
  output logic [N_FU-1:0][XLEN-1:0]          o_iss_src1,
  output logic [N_FU-1:0][TAG_W-1:0]         o_iss_dst_tag,
  output logic [N_FU-1:0][ROB_W-1:0]         o_iss_rob,
  output logic [N_FU-1:0][PAYLOAD_W-1:0]     o_iss_payload,
  output logic [CNT_W-1:0]                   o_count
);

  logic [DEPTH-1:0]                 valid, s0_rdy, s1_rdy;
  logic [DEPTH-1:0][DEPTH-1:0]      older;
  logic [DEPTH-1:0][TAG_W-1:0]      s0_tag, s1_tag, dst;
  logic [DEPTH-1:0][XLEN-1:0]       s0_data, s1_data;
  logic [DEPTH-1:0][ROB_W-1:0]      rob;
  logic [DEPTH-1:0][FU_W-1:0]       fu;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]  payload;

  logic [N_DISP-1:0][IDX_W-1:0]     free_idx, slot;
  logic [N_DISP-1:0]                cap0_rdy, cap1_rdy;
  logic [N_DISP-1:0][XLEN-1:0]      cap0_data, cap1_data;
  logic [N_FU-1:0][DEPTH-1:0]       cand, sel;
  logic [DEPTH-1:0]                 free_mask, alloc_mask;
  logic                             disp_fire;
  int                               nf, rank;

  always_comb begin
    o_count = '0;
    for (int e = 0; e < DEPTH; e++) o_count = o_count + CNT_W'(valid[e]);
  end

  assign o_disp_ready = (CNT_W'(DEPTH) - o_count) >= CNT_W'(N_DISP);
  assign disp_fire    = o_disp_ready && !i_flush;

  // Lane i takes the rank-th free entry, rank = valid lanes below i.
  always_comb begin
    free_idx   = '0;
    slot       = '0;
    alloc_mask = '0;
    nf         = 0;
    rank       = 0;
    for (int e = 0; e < DEPTH; e++)
      if (!valid[e]) begin
        for (int j = 0; j < N_DISP; j++)
          if (nf == j) free_idx[j] = IDX_W'(e);
        nf = nf + 1;
      end
    for (int i = 0; i < N_DISP; i++) begin
      for (int j = 0; j < N_DISP; j++)
        if (rank == j) slot[i] = free_idx[j];
      if (i_disp_valid[i]) rank = rank + 1;
    end
    for (int i = 0; i < N_DISP; i++)
      for (int e = 0; e < DEPTH; e++)
        if (disp_fire && i_disp_valid[i] && slot[i] == IDX_W'(e)) alloc_mask[e] = 1'b1;
  end

  // Buses are scanned high to low so the lowest matching bus index wins.
  always_comb begin
    for (int i = 0; i < N_DISP; i++) begin
      cap0_rdy[i]  = i_disp_src0_rdy[i] || (i_disp_src0_tag[i] == '0);
      cap1_rdy[i]  = i_disp_src1_rdy[i] || (i_disp_src1_tag[i] == '0);
      cap0_data[i] = (i_disp_src0_tag[i] == '0) ? '0 : i_disp_src0_data[i];
      cap1_data[i] = (i_disp_src1_tag[i] == '0) ? '0 : i_disp_src1_data[i];
      for (int b = N_WB - 1; b >= 0; b--) begin
        if (i_wb_valid[b] && i_wb_tag[b] == i_disp_src0_tag[i]) begin
          cap0_rdy[i]  = 1'b1;
          cap0_data[i] = i_wb_data[b];
        end
        if (i_wb_valid[b] && i_wb_tag[b] == i_disp_src1_tag[i]) begin
          cap1_rdy[i]  = 1'b1;
          cap1_data[i] = i_wb_data[b];
        end
      end
    end
  end

  // Oldest candidate per FU: no other candidate is older than it (one-hot).
  always_comb begin
    cand          = '0;
    sel           = '0;
    free_mask     = '0;
    o_iss_valid   = '0;
    o_iss_src0    = '0;
    o_iss_src1    = '0;
    o_iss_dst_tag = '0;
    o_iss_rob     = '0;
    o_iss_payload = '0;
    for (int k = 0; k < N_FU; k++) begin
      for (int e = 0; e < DEPTH; e++)
        cand[k][e] = valid[e] && s0_rdy[e] && s1_rdy[e] && (fu[e] == FU_W'(k));
      for (int e = 0; e < DEPTH; e++) begin
        sel[k][e] = cand[k][e];
        for (int x = 0; x < DEPTH; x++)
          if (cand[k][x] && older[x][e]) sel[k][e] = 1'b0;
      end
      o_iss_valid[k] = |cand[k];
      for (int e = 0; e < DEPTH; e++)
        if (sel[k][e]) begin
          o_iss_src0[k]    = s0_data[e];
          o_iss_src1[k]    = s1_data[e];
          o_iss_dst_tag[k] = dst[e];
          o_iss_rob[k]     = rob[e];
          o_iss_payload[k] = payload[e];
        end
      if (o_iss_valid[k] && i_iss_ready[k]) free_mask = free_mask | sel[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= '0;
      older <= '0;
    end else if (i_flush) begin
      valid <= '0;
    end else begin
      valid <= (valid & ~free_mask) | alloc_mask;
      for (int i = 0; i < N_DISP; i++)
        if (disp_fire && i_disp_valid[i]) begin
          for (int y = 0; y < DEPTH; y++) begin
            older[slot[i]][y] <= 1'b0;
            older[y][slot[i]] <= valid[y];
          end
          for (int j = 0; j < i; j++)
            if (i_disp_valid[j]) older[slot[j]][slot[i]] <= 1'b1;
        end
    end
  end

  // Entry contents only matter while valid, so they carry no reset.
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      for (int b = N_WB - 1; b >= 0; b--) begin
        if (i_wb_valid[b] && valid[e] && !s0_rdy[e] && s0_tag[e] == i_wb_tag[b]) begin
          s0_rdy[e]  <= 1'b1;
          s0_data[e] <= i_wb_data[b];
        end
        if (i_wb_valid[b] && valid[e] && !s1_rdy[e] && s1_tag[e] == i_wb_tag[b]) begin
          s1_rdy[e]  <= 1'b1;
          s1_data[e] <= i_wb_data[b];
        end
      end
      for (int i = 0; i < N_DISP; i++)
        if (disp_fire && i_disp_valid[i] && slot[i] == IDX_W'(e)) begin
          s0_tag[e]  <= i_disp_src0_tag[i];
          s1_tag[e]  <= i_disp_src1_tag[i];
          s0_rdy[e]  <= cap0_rdy[i];
          s1_rdy[e]  <= cap1_rdy[i];
          s0_data[e] <= cap0_data[i];
          s1_data[e] <= cap1_data[i];
          dst[e]     <= i_disp_dst_tag[i];
          rob[e]     <= i_disp_rob[i];
          fu[e]      <= i_disp_fu[i];
          payload[e] <= i_disp_payload[i];
        end
    end
  end

endmodule
